conv_mdc_tcdm_responder: RTL and testbench

TCDM slave-side responder for the conv_mdc HWPE: it terminates the streamer's `MP` TCDM master ports and serves their load and store requests from an internal single-ported word memory. A round-robin arbiter grants at most one request per cycle, and responses return with fixed one-cycle latency. It serves as the memory end of the streamer's TCDM protocol in unit and subsystem benches, and as a scratch-memory stand-in in FPGA bring-up builds.

---
 rtl/conv_mdc_tcdm_responder_pkg.sv | 28 ++
 rtl/conv_mdc_tcdm_responder_if.sv | 24 ++
 rtl/conv_mdc_tcdm_responder_arb.sv | 48 ++++
 rtl/conv_mdc_tcdm_responder.sv | 131 +++++++++++++
 tb/tb_conv_mdc_tcdm_responder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mdc_tcdm_responder_pkg.sv
// Shared types and constants for the conv_mdc TCDM responder.
package conv_mdc_package;

   localparam int unsigned TCDM_DW        = 32;
   localparam int unsigned TCDM_BW        = 4;
   localparam logic [15:0] TCDM_LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic        busy;
      logic [31:0] nb_reads;
      logic [31:0] nb_writes;
   } tcdm_resp_flags_t;

   // Byte-enable merge of a write word onto the stored word.
   function automatic logic [TCDM_DW-1:0] tcdm_be_merge(
      input logic [TCDM_DW-1:0] old_d,
      input logic [TCDM_DW-1:0] wr_d,
      input logic [TCDM_BW-1:0] be
   );
      logic [TCDM_DW-1:0] res;
      res = old_d;
      for (int i = 0; i < int'(TCDM_BW); i++) begin
         if (be[i]) res[8*i +: 8] = wr_d[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_mdc_tcdm_responder_if.sv
// One TCDM port: request/grant handshake plus a one-cycle response channel.
interface hwpe_stream_intf_tcdm;
   import conv_mdc_package::*;

   logic               req;
   logic               gnt;
   logic [TCDM_DW-1:0] add;
   logic               wen;
   logic [TCDM_BW-1:0] be;
   logic [TCDM_DW-1:0] data;
   logic [TCDM_DW-1:0] r_data;
   logic               r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/conv_mdc_tcdm_responder_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: combinational grant; pointer moves to winner+1 at the next edge.
// Backpressure: en low or no request leaves gnt at zero and the pointer in place.
module conv_mdc_rr_arbiter #(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          en,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] r_rr;
   logic [IW:0]   w_sum;
   logic [IW-1:0] w_k;
   logic          w_any;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      w_any = 1'b0;
      w_sum = '0;
      w_k   = '0;
      for (int i = 0; i < int'(N); i++) begin
         w_sum = {1'b0, r_rr} + (IW+1)'(i);
         if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
         w_k = w_sum[IW-1:0];
         if (en && !w_any && req[w_k]) begin
            w_any    = 1'b1;
            gnt[w_k] = 1'b1;
            idx      = w_k;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_rr <= '0;
      end else if (w_any) begin
         r_rr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/conv_mdc_tcdm_responder.sv
// TCDM responder: MP slave ports served round-robin from one word memory; CONV_MDC_TCDM_STALL_EN adds LFSR grant stalls.
// Latency: grant combinational, r_valid/r_data exactly one cycle after the grant.
// Backpressure: one grant per cycle, losers hold their request; responses are never stalled.
module conv_mdc_tcdm_responder
   import conv_mdc_package::*;
#(
   parameter int unsigned MP       = 2,
   parameter int unsigned NB_WORDS = 1024,
   parameter int unsigned AW       = $clog2(NB_WORDS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                clear_i,
   hwpe_stream_intf_tcdm.slave tcdm [MP-1:0],
   output tcdm_resp_flags_t    flags_o
);

   localparam int unsigned IW = (MP > 1) ? $clog2(MP) : 1;

   logic [MP-1:0]      w_req;
   logic [MP-1:0]      w_wen;
   logic [MP-1:0]      w_gnt;
   logic [MP-1:0]      w_rvalid;
   logic [TCDM_DW-1:0] w_add  [MP];
   logic [TCDM_DW-1:0] w_data [MP];
   logic [TCDM_BW-1:0] w_be   [MP];
   logic [IW-1:0]      w_idx;
   logic               w_soft_rst;
   logic               w_stall;
   logic               w_en;
   logic               w_any_gnt;
   logic [TCDM_DW-1:0] w_sel_add;
   logic [TCDM_DW-1:0] w_sel_data;
   logic [TCDM_BW-1:0] w_sel_be;
   logic               w_sel_wen;
   logic [AW-1:0]      w_word;
   logic               w_unused;
   logic [TCDM_DW-1:0] r_mem [NB_WORDS];
   logic [31:0]        r_nb_reads;
   logic [31:0]        r_nb_writes;

   assign w_soft_rst = !rst_ni || clear_i;

`ifdef CONV_MDC_TCDM_STALL_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk_i) begin
      if (w_soft_rst) begin
         r_lfsr <= TCDM_LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      end
   end

   assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
   assign w_stall = 1'b0;
`endif

   assign w_en = enable_i && !w_soft_rst && !w_stall;

   conv_mdc_rr_arbiter #(
      .N (MP)
   ) i_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .en      (w_en),
      .req     (w_req),
      .gnt     (w_gnt),
      .idx     (w_idx)
   );

   assign w_any_gnt  = |w_gnt;
   assign w_sel_add  = w_add[w_idx];
   assign w_sel_data = w_data[w_idx];
   assign w_sel_be   = w_be[w_idx];
   assign w_sel_wen  = w_wen[w_idx];
   // Byte offset and bits above the array range are dropped, so addresses wrap.
   assign w_word     = w_sel_add[AW+1:2];
   assign w_unused   = ^{w_sel_add[TCDM_DW-1:AW+2], w_sel_add[1:0]};

   // Grants already exclude reset and clear cycles, so no write can land then.
   always_ff @(posedge clk_i) begin
      if (w_any_gnt && !w_sel_wen) begin
         r_mem[w_word] <= tcdm_be_merge(r_mem[w_word], w_sel_data, w_sel_be);
      end
   end

   for (genvar g = 0; g < int'(MP); g++) begin : g_port
      logic               r_rvalid;
      logic [TCDM_DW-1:0] r_rdata;

      assign w_req[g]  = tcdm[g].req;
      assign w_wen[g]  = tcdm[g].wen;
      assign w_add[g]  = tcdm[g].add;
      assign w_data[g] = tcdm[g].data;
      assign w_be[g]   = tcdm[g].be;

      always_ff @(posedge clk_i) begin
         if (w_soft_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
         end else begin
            r_rvalid <= w_gnt[g];
            r_rdata  <= (w_gnt[g] && w_wen[g]) ? r_mem[w_word] : '0;
         end
      end

      assign w_rvalid[g]     = r_rvalid;
      assign tcdm[g].gnt     = w_gnt[g];
      assign tcdm[g].r_valid = r_rvalid;
      assign tcdm[g].r_data  = r_rdata;
   end

   always_ff @(posedge clk_i) begin
      if (w_soft_rst) begin
         r_nb_reads  <= '0;
         r_nb_writes <= '0;
      end else if (w_any_gnt) begin
         if (w_sel_wen) r_nb_reads  <= r_nb_reads + 32'd1;
         else           r_nb_writes <= r_nb_writes + 32'd1;
      end
   end

   assign flags_o.busy      = (|w_req) || (|w_rvalid);
   assign flags_o.nb_reads  = r_nb_reads;
   assign flags_o.nb_writes = r_nb_writes;

endmodule

// File: tb/tb_conv_mdc_tcdm_responder.sv
// Randomized bench for conv_mdc_tcdm_responder with a cycle-level reference model.
module tb_conv_mdc_tcdm_responder;
   import conv_mdc_package::*;

   localparam int MP = 2;
   localparam int NW = 1024;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             enable = 1'b0;
   logic             clear  = 1'b0;
   logic [MP-1:0]    b_req  = '0;
   logic [MP-1:0]    b_wen  = '0;
   logic [31:0]      b_add  [MP];
   logic [31:0]      b_data [MP];
   logic [3:0]       b_be   [MP];
   logic [MP-1:0]    d_gnt;
   logic [MP-1:0]    d_rvalid;
   logic [31:0]      d_rdata [MP];
   tcdm_resp_flags_t flags;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hwpe_stream_intf_tcdm tcdm_if [1:0] ();

   for (genvar g = 0; g < MP; g++) begin : g_if
      assign tcdm_if[g].req  = b_req[g];
      assign tcdm_if[g].add  = b_add[g];
      assign tcdm_if[g].wen  = b_wen[g];
      assign tcdm_if[g].be   = b_be[g];
      assign tcdm_if[g].data = b_data[g];
      assign d_gnt[g]        = tcdm_if[g].gnt;
      assign d_rvalid[g]     = tcdm_if[g].r_valid;
      assign d_rdata[g]      = tcdm_if[g].r_data;
   end

   conv_mdc_tcdm_responder #(
      .MP       (MP),
      .NB_WORDS (NW)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .enable_i (enable),
      .clear_i  (clear),
      .tcdm     (tcdm_if),
      .flags_o  (flags)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image plus what each output must show after the next edge.
   logic [31:0] m_mem   [NW];
   bit          m_known [NW];
   bit          m_rv    [MP];
   logic [31:0] m_rd    [MP];
   bit          m_rdk   [MP];
   int          m_rr    = 0;
   int unsigned m_nr    = 0;
   int unsigned m_nw    = 0;
   int unsigned m_lfsr  = 32'hACE1;
   bit          m_ok    = 1'b0;
   int          gcnt    [MP];
   int          n_both  = 0;

   always @(negedge clk) begin
      int  g;
      int  w;
      bit  allow;
      bit  any_rv;
      if (m_ok) begin
         any_rv = 1'b0;
         for (int k = 0; k < MP; k++) begin
            any_rv = any_rv | m_rv[k];
            check("r_valid", 64'(d_rvalid[k]), 64'(m_rv[k]));
            if (!m_rv[k]) check("r_data_idle", 64'(d_rdata[k]), 64'd0);
            else if (m_rdk[k]) check("r_data", 64'(d_rdata[k]), 64'(m_rd[k]));
         end
         check("nb_reads", 64'(flags.nb_reads), 64'(m_nr));
         check("nb_writes", 64'(flags.nb_writes), 64'(m_nw));
         check("busy", 64'(flags.busy), 64'((|b_req) || any_rv));
      end
      allow = rst_n && enable && !clear;
`ifdef CONV_MDC_TCDM_STALL_EN
      allow = allow && ((m_lfsr % 4) != 0);
`endif
      g = -1;
      for (int i = 0; i < MP; i++) begin
         int k;
         k = (m_rr + i) % MP;
         if (allow && g < 0 && b_req[k]) g = k;
      end
      for (int k = 0; k < MP; k++) begin
         check("gnt", 64'(d_gnt[k]), 64'(k == g));
         if (d_gnt[k]) gcnt[k]++;
      end
      if (&d_gnt) n_both++;
      if (!rst_n || clear) begin
         m_rr = 0;
         m_nr = 0;
         m_nw = 0;
         m_lfsr = 32'hACE1;
         for (int k = 0; k < MP; k++) begin
            m_rv[k] = 1'b0; m_rd[k] = '0; m_rdk[k] = 1'b1;
         end
         m_ok = 1'b1;
      end else begin
         for (int k = 0; k < MP; k++) begin
            m_rv[k] = 1'b0; m_rd[k] = '0; m_rdk[k] = 1'b1;
         end
         if (g >= 0) begin
            w = int'((b_add[g] >> 2) % NW);
            m_rv[g] = 1'b1;
            if (b_wen[g]) begin
               m_rd[g]  = m_mem[w];
               m_rdk[g] = m_known[w];
               m_nr++;
            end else begin
               for (int b = 0; b < 4; b++)
                  if (b_be[g][b]) m_mem[w][8*b +: 8] = b_data[g][8*b +: 8];
               if (b_be[g] == 4'hF) m_known[w] = 1'b1;
               m_nw++;
            end
            m_rr = (g + 1) % MP;
         end
         m_lfsr = (m_lfsr >> 1) | ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
      end
   end

   // Entered and left at posedge+1; holds the request until granted.
   task automatic access(input int p, input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] d, output logic [31:0] rd);
      int t;
      b_req[p] = 1'b1; b_add[p] = a; b_wen[p] = w; b_be[p] = be; b_data[p] = d;
      t = 0;
      #3;
      while (!d_gnt[p] && t < 100) begin
         @(posedge clk); #4;
         t++;
      end
      check("grant_within_budget", 64'(d_gnt[p]), 64'd1);
      @(posedge clk); #1;
      rd = d_rdata[p];
      check("r_valid_one_cycle_after_grant", 64'(d_rvalid[p]), 64'd1);
      b_req[p] = 1'b0;
   endtask

   task automatic randomize_port(input int p);
      logic [31:0] a;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom() & 32'hFFFF_F000);
      b_add[p]  = a;
      b_wen[p]  = 1'($urandom_range(0, 1));
      b_be[p]   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      b_data[p] = $urandom();
   endtask

   initial begin
      logic [31:0]   rd;
      logic [MP-1:0] gs;
      int            t;
      for (int k = 0; k < MP; k++) begin
         b_add[k] = '0; b_data[k] = '0; b_be[k] = '0;
      end
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_nb_reads", 64'(flags.nb_reads), 64'd0);
      check("reset_nb_writes", 64'(flags.nb_writes), 64'd0);
      check("reset_r_valid", 64'(d_rvalid), 64'd0);

      access(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF, rd);
      access(0, 32'h10, 1'b1, 4'h0, 32'h0, rd);
      check("write_read_data", 64'(rd), 64'hDEADBEEF);
      check("write_read_nb_writes", 64'(flags.nb_writes), 64'd1);
      check("write_read_nb_reads", 64'(flags.nb_reads), 64'd1);

      access(1, 32'h10, 1'b0, 4'b0101, 32'h11223344, rd);
      access(1, 32'h10, 1'b1, 4'h0, 32'h0, rd);
      check("partial_write", 64'(rd), 64'hDE22BE44);

      access(0, 32'h1000, 1'b0, 4'hF, 32'hA5A5A5A5, rd);
      access(1, 32'h0, 1'b1, 4'h0, 32'h0, rd);
      check("address_wrap", 64'(rd), 64'hA5A5A5A5);

      access(0, 32'h20, 1'b0, 4'hF, 32'h12345678, rd);
      access(1, 32'h20, 1'b1, 4'h0, 32'h0, rd);
      check("word_0x20", 64'(rd), 64'h12345678);

      // Both ports hammer for eight cycles starting with the pointer at port 0.
      gcnt[0] = 0; gcnt[1] = 0; n_both = 0;
      b_req = 2'b11;
      b_add[0] = 32'h10; b_wen[0] = 1'b1;
      b_add[1] = 32'h0;  b_wen[1] = 1'b1;
      repeat (8) @(posedge clk);
      #1 b_req = '0;
      check("contention_never_both", 64'(n_both), 64'd0);
`ifndef CONV_MDC_TCDM_STALL_EN
      check("contention_port0", 64'(gcnt[0]), 64'd4);
      check("contention_port1", 64'(gcnt[1]), 64'd4);
`endif

      // Reset lands one cycle after a read grant; a write is requested while in reset.
      b_req[0] = 1'b1; b_add[0] = 32'h20; b_wen[0] = 1'b1; b_be[0] = 4'h0;
      t = 0;
      #3;
      while (!d_gnt[0] && t < 100) begin
         @(posedge clk); #4;
         t++;
      end
      check("reset_test_grant", 64'(d_gnt[0]), 64'd1);
      @(posedge clk); #1;
      check("reset_test_resp_before_edge", 64'(d_rvalid[0]), 64'd1);
      rst_n = 1'b0;
      b_req[0] = 1'b0;
      b_req[1] = 1'b1; b_add[1] = 32'h20; b_wen[1] = 1'b0; b_be[1] = 4'hF; b_data[1] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      check("reset_drops_response", 64'(d_rvalid[0]), 64'd0);
      check("reset_clears_nb_reads", 64'(flags.nb_reads), 64'd0);
      check("reset_clears_nb_writes", 64'(flags.nb_writes), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      b_req = 2'b11;
      b_add[0] = 32'h20; b_wen[0] = 1'b1;
      b_add[1] = 32'h20; b_wen[1] = 1'b1;
      #3;
`ifndef CONV_MDC_TCDM_STALL_EN
      check("pointer_zero_after_reset", 64'(d_gnt), 64'd1);
`endif
      @(posedge clk); #1 b_req[0] = 1'b0;
      @(posedge clk); #1 b_req[1] = 1'b0;
      access(0, 32'h20, 1'b1, 4'h0, 32'h0, rd);
      check("no_write_during_reset", 64'(rd), 64'h12345678);

      access(1, 32'h30, 1'b0, 4'hF, 32'h0BADF00D, rd);
      clear = 1'b1;
      b_req[0] = 1'b1; b_add[0] = 32'h30; b_wen[0] = 1'b0; b_be[0] = 4'hF; b_data[0] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      clear = 1'b0;
      b_req[0] = 1'b0;
      access(0, 32'h30, 1'b1, 4'h0, 32'h0, rd);
      check("no_write_during_clear", 64'(rd), 64'h0BADF00D);

      // 1000 cycles of continuous requests, then a mixed phase with enable/clear noise.
      gs = '0;
      for (int c = 0; c < 2500; c++) begin
         bit cont;
         cont   = (c < 1000);
         enable = cont ? 1'b1 : 1'($urandom_range(0, 9) != 0);
         clear  = cont ? 1'b0 : 1'($urandom_range(0, 199) == 0);
         for (int p = 0; p < MP; p++) begin
            if (!b_req[p] || gs[p]) begin
               randomize_port(p);
               b_req[p] = cont ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            end
         end
         #3 gs = d_gnt;
         @(posedge clk); #1;
      end

      b_req  = '0;
      enable = 1'b1;
      clear  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
